imem_boot_loader: RTL and testbench

Program loader that sits directly upstream of `single_cycle_top`. It receives a byte stream (header, instruction words, checksum) over a valid/ready interface and writes the words into the instruction-memory write port. It holds the core in reset until the image is loaded and verified, then releases `core_rst` so the processor starts fetching from address 0.

---
 rtl/single_cycle_pkg.sv | 21 ++
 rtl/boot_word_assembler.sv | 50 +++++
 rtl/imem_boot_loader.sv | 143 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/single_cycle_pkg.sv
// Shared definitions for the instruction-memory boot loader: loader states and
// image framing constants.
package single_cycle_pkg;

    typedef enum logic [2:0] {
        StHdr,
        StData,
        StCsum,
        StDone,
        StErr
    } load_state_e;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

    // States in which the loader still consumes stream bytes.
    function automatic logic is_active(input load_state_e s);
        return (s == StHdr) || (s == StData) || (s == StCsum);
    endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Packs little-endian stream bytes into 32-bit words and keeps the running XOR
// of every data byte for the trailing checksum.
module boot_word_assembler
    import single_cycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en,
    input  logic [7:0]  in_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  cnt_q;
    logic [31:0] asm_q;
    logic [31:0] word_q;
    logic        word_valid_q;
    logic [7:0]  csum_q;

    assign last_byte = (cnt_q == 2'(WORD_BYTES - 1));

    // Bytes shift in from the top, so after four bytes byte 0 sits in [7:0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= 2'd0;
            asm_q        <= 32'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
            csum_q       <= 8'd0;
        end else begin
            word_valid_q <= 1'b0;
            if (byte_en) begin
                cnt_q  <= cnt_q + 2'd1;
                asm_q  <= {in_data, asm_q[31:8]};
                csum_q <= csum_q ^ in_data;
                if (last_byte) begin
                    word_q       <= {in_data, asm_q[31:8]};
                    word_valid_q <= 1'b1;
                end
            end
        end
    end

    assign word_valid = word_valid_q;
    assign word       = word_q;
    assign csum       = csum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed, XOR-checked image into instruction
// memory and releases the core reset once the image verifies.
module imem_boot_loader
    import single_cycle_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [32:0] MaxWords = 33'd1 << ADDR_WIDTH;

    load_state_e           state_q, state_d;
    logic [23:0]           hdr_q;
    logic [1:0]            hdr_cnt_q;
    logic [ADDR_WIDTH-1:0] n_last_q;
    logic [ADDR_WIDTH-1:0] widx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  in_ready_q;
    logic                  load_done_q;
    logic                  load_err_q;
    logic                  core_rst_q;

    logic        fire;
    logic        hdr_last;
    logic [31:0] hdr_word;
    logic        len_zero;
    logic        len_bad;
    logic        data_en;
    logic        last_byte;
    logic        word_valid;
    logic [31:0] word;
    logic [7:0]  csum;

    assign fire     = in_valid && in_ready_q;
    assign hdr_last = (hdr_cnt_q == 2'(HDR_BYTES - 1));
    assign hdr_word = {in_data, hdr_q};
    assign len_zero = (hdr_word == 32'd0);
    assign len_bad  = ({1'b0, hdr_word} > MaxWords);
    assign data_en  = fire && (state_q == StData);

    boot_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_en    (data_en),
        .in_data    (in_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHdr: begin
                if (fire && hdr_last) begin
                    if (len_bad) begin
                        state_d = StErr;
                    end else if (len_zero) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (fire && last_byte && (widx_q == n_last_q)) begin
                    state_d = StCsum;
                end
            end
            StCsum: begin
                if (fire) begin
                    state_d = (in_data == csum) ? StDone : StErr;
                end
            end
            StDone, StErr: state_d = state_q;
            default:       state_d = StErr;
        endcase
    end

    // Status flags track the next state so they rise together with the transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StHdr;
            in_ready_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            core_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= is_active(state_d);
            load_done_q <= (state_d == StDone);
            load_err_q  <= (state_d == StErr);
            core_rst_q  <= (state_d == StDone);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_q     <= 24'd0;
            hdr_cnt_q <= 2'd0;
            n_last_q  <= '0;
        end else if (fire && (state_q == StHdr)) begin
            hdr_q     <= {in_data, hdr_q[23:8]};
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            // N-1 always fits once the length check passes; unused when N is 0.
            if (hdr_last) begin
                n_last_q <= ADDR_WIDTH'(hdr_word - 32'd1);
            end
        end
    end

    // The write address is latched with the word so it holds until the next write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            widx_q <= '0;
            addr_q <= '0;
        end else if (data_en && last_byte) begin
            addr_q <= widx_q;
            widx_q <= widx_q + ADDR_WIDTH'(1);
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = word_valid;
    assign mem_addr  = addr_q;
    assign mem_wdata = word;
    assign core_rst  = core_rst_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a byte-level image model checks every
// output each cycle, with a few literal expectations pinning the model.
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    logic        in_valid2;
    logic        in_ready2;
    logic        mem_we2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic        core_rst2;
    logic        load_done2;
    logic        load_err2;

    imem_boot_loader #(.ADDR_WIDTH(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    imem_boot_loader #(.ADDR_WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .mem_we    (mem_we2),
        .mem_addr  (mem_addr2),
        .mem_wdata (mem_wdata2),
        .core_rst  (core_rst2),
        .load_done (load_done2),
        .load_err  (load_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: everything follows from the list of accepted bytes.
    localparam longint unsigned Cap = 1024;
    logic [7:0]      mq[$];
    longint unsigned mn;
    bit              mterm;
    bit              m_fire;
    int              mp;
    logic [7:0]      mx;
    logic            e_ready, e_we, e_done, e_err;
    logic [9:0]      e_addr;
    logic [31:0]     e_wdata;

    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            mn      = 0;
            mterm   = 0;
            e_ready = 0;
            e_we    = 0;
            e_addr  = 0;
            e_wdata = 0;
            e_done  = 0;
            e_err   = 0;
        end
        check("in_ready", in_ready, e_ready);
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("load_done", load_done, e_done);
        check("core_rst", core_rst, e_done);
        check("load_err", load_err, e_err);
        if (rst) begin
            m_fire = in_valid && e_ready;
            e_we   = 0;
            if (m_fire) begin
                mq.push_back(in_data);
                mp = mq.size();
                if (mp == 4) begin
                    mn = {32'd0, mq[3], mq[2], mq[1], mq[0]};
                    if (mn > Cap) begin
                        mterm = 1;
                        e_err = 1;
                    end
                end else if (mp > 4 && longint'(mp) <= 4 + 4 * mn) begin
                    if ((mp - 4) % 4 == 0) begin
                        e_we    = 1;
                        e_addr  = 10'((mp - 4) / 4 - 1);
                        e_wdata = {mq[mp-1], mq[mp-2], mq[mp-3], mq[mp-4]};
                    end
                end else if (longint'(mp) == 4 + 4 * mn + 1) begin
                    mx = 0;
                    for (int i = 4; i < mp - 1; i++) mx ^= mq[i];
                    if (mx == mq[mp-1]) e_done = 1;
                    else e_err = 1;
                    mterm = 1;
                end
            end
            e_ready = !mterm;
        end
    end

    logic [9:0]  wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          we2_count = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
        end
        if (mem_we2 === 1'b1) we2_count++;
    end

    logic [31:0] img_words[$];

    function automatic logic [7:0] calc_csum();
        logic [7:0] x = 8'd0;
        foreach (img_words[i]) begin
            x ^= img_words[i][7:0] ^ img_words[i][15:8] ^ img_words[i][23:16] ^ img_words[i][31:24];
        end
        return x;
    endfunction

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit to2);
        bit ok = 0;
        repeat (gap) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        if (to2) in_valid2 = 1'b1;
        else in_valid = 1'b1;
        in_data = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = to2 ? in_ready2 : in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL handshake: in_ready stayed 0, byte %0h not accepted", b);
        end
    endtask

    task automatic send_image(input int unsigned n, input logic [7:0] cs, input int maxgap);
        for (int i = 0; i < 4; i++) send_byte(8'(n >> (8 * i)), $urandom_range(0, maxgap), 1'b0);
        for (int w = 0; w < int'(n); w++) begin
            for (int i = 0; i < 4; i++) begin
                send_byte(8'(img_words[w] >> (8 * i)), $urandom_range(0, maxgap), 1'b0);
            end
        end
        send_byte(cs, $urandom_range(0, maxgap), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wlog_addr.delete();
        wlog_data.delete();
        rst = 1'b1;
    endtask

    // Terminal states must ignore offered bytes.
    task automatic offer_idle_bytes();
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic image_a(input int maxgap);
        do_reset();
        img_words = '{32'h00500093, 32'h00A00113};
        send_image(2, 8'h71, maxgap);
        check("a_done", load_done, 1'b1);
        check("a_core_rst", core_rst, 1'b1);
        check("a_ready_low", in_ready, 1'b0);
        check("a_write_count", wlog_addr.size(), 2);
        if (wlog_addr.size() == 2) begin
            check("a_addr0", wlog_addr[0], 10'd0);
            check("a_data0", wlog_data[0], 32'h00500093);
            check("a_addr1", wlog_addr[1], 10'd1);
            check("a_data1", wlog_data[1], 32'h00A00113);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        in_data   = 8'd0;
        #1 rst = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 10'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_rst", core_rst, 1'b0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_load_err", load_err, 1'b0);

        image_a(0);
        offer_idle_bytes();
        image_a(5);

        do_reset();
        img_words = '{32'h12345678};
        send_image(1, 8'h00, 0);
        check("bad_csum_err", load_err, 1'b1);
        check("bad_csum_core_rst", core_rst, 1'b0);
        check("bad_csum_ready", in_ready, 1'b0);
        offer_idle_bytes();
        check("bad_csum_err_sticky", load_err, 1'b1);

        do_reset();
        img_words.delete();
        send_image(0, 8'h00, 0);
        check("n0_done", load_done, 1'b1);
        check("n0_no_writes", wlog_addr.size(), 0);
        do_reset();
        send_image(0, 8'h01, 0);
        check("n0_bad_err", load_err, 1'b1);
        check("n0_bad_done", load_done, 1'b0);

        do_reset();
        send_byte(8'h05, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        check("len_err_early", load_err2, 1'b0);
        send_byte(8'h00, 0, 1'b1);
        check("len_err", load_err2, 1'b1);
        check("len_err_ready", in_ready2, 1'b0);
        check("len_err_core_rst", core_rst2, 1'b0);

        do_reset();
        img_words = '{32'h11111111, 32'h22222222};
        for (int i = 0; i < 4; i++) send_byte(8'(2 >> (8 * i)), 0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'(img_words[0] >> (8 * i)), 0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'(img_words[1] >> (8 * i)), 0, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_mem_we", mem_we, 1'b0);
        check("abort_mem_addr", mem_addr, 10'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        check("abort_core_rst", core_rst, 1'b0);
        check("abort_done", load_done, 1'b0);
        check("abort_err", load_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        wlog_addr.delete();
        wlog_data.delete();
        rst = 1'b1;
        img_words = '{32'hDEADBEEF};
        send_image(1, calc_csum(), 2);
        check("reload_done", load_done, 1'b1);
        check("reload_writes", wlog_addr.size(), 1);
        if (wlog_addr.size() == 1) begin
            check("reload_addr", wlog_addr[0], 10'd0);
            check("reload_data", wlog_data[0], 32'hDEADBEEF);
        end

        for (int it = 0; it < 25; it++) begin
            int unsigned n;
            logic [7:0]  cs;
            bit          good;
            do_reset();
            n = $urandom_range(0, 5);
            img_words.delete();
            for (int w = 0; w < int'(n); w++) img_words.push_back($urandom);
            cs   = calc_csum();
            good = 1;
            if ($urandom_range(0, 3) == 0) begin
                cs   = cs ^ 8'(1 << $urandom_range(0, 7));
                good = 0;
            end
            if ($urandom_range(0, 4) == 0) begin
                int k = $urandom_range(1, 4 + 4 * n);
                for (int i = 0; i < k; i++) send_byte(8'($urandom), $urandom_range(0, 2), 1'b0);
            end else begin
                send_image(n, cs, 3);
                check("rand_done", load_done, good);
                check("rand_err", load_err, !good);
                check("rand_writes", wlog_addr.size(), n);
                offer_idle_bytes();
            end
        end

        check("dut2_no_writes", we2_count, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
